// File: rtl/add_seq_pkg.sv
// Shared types and default sizing for the multi-precision add/subtract sequencer.
package add_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_e;

    localparam int WORD_W_DEF    = 32;
    localparam int NUM_WORDS_DEF = 4;

endpackage

// File: rtl/cla_cin.sv
// Combinational WORD_W-bit carry-lookahead adder with carry-in.
module cla_cin #(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] i_data_a,
    input  logic [WORD_W-1:0] i_data_b,
    input  logic              i_carry,
    output logic [WORD_W-1:0] o_data,
    output logic              o_carry
);

    logic [WORD_W-1:0] gen_s;
    logic [WORD_W-1:0] prop_s;
    logic [WORD_W:0]   carry_s;

    // Each carry is a flat sum-of-products of generate/propagate terms, not a ripple chain.
    function automatic logic [WORD_W:0] lookahead(input logic [WORD_W-1:0] g,
                                                  input logic [WORD_W-1:0] p,
                                                  input logic cin);
        logic [WORD_W:0] c;
        logic            term;
        logic            prod;
        c[0] = cin;
        for (int i = 0; i < WORD_W; i++) begin
            term = 1'b0;
            prod = 1'b1;
            for (int j = i; j >= 0; j--) begin
                term = term | (g[j] & prod);
                prod = prod & p[j];
            end
            c[i+1] = term | (prod & cin);
        end
        return c;
    endfunction

    // Per-bit generate/propagate, lookahead carries and sum.
    always_comb begin
        gen_s   = i_data_a & i_data_b;
        prop_s  = i_data_a ^ i_data_b;
        carry_s = lookahead(gen_s, prop_s, i_carry);
        o_data  = prop_s ^ carry_s[WORD_W-1:0];
        o_carry = carry_s[WORD_W];
    end

endmodule

// File: rtl/wide_add_seq.sv
// Multi-precision add/subtract sequencer: one shared word adder, LSW first, carry chained in a register.
module wide_add_seq
    import add_seq_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int NUM_WORDS = NUM_WORDS_DEF
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic                        i_sub,
    input  logic [WORD_W*NUM_WORDS-1:0] i_data_a,
    input  logic [WORD_W*NUM_WORDS-1:0] i_data_b,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [WORD_W*NUM_WORDS-1:0] o_data,
    output logic                        o_carry,
    output logic                        o_busy
);

    localparam int TOT_W = WORD_W * NUM_WORDS;
    localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

    seq_state_e        state_r;
    seq_state_e        state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              carry_r;
    logic [TOT_W-1:0]  a_r;
    logic [TOT_W-1:0]  b_r;
    logic [TOT_W-1:0]  data_r;
    logic              ocarry_r;
    logic [WORD_W-1:0] a_slice_s;
    logic [WORD_W-1:0] b_slice_s;
    logic [WORD_W-1:0] sum_s;
    logic              word_carry_s;
    logic              last_s;
    int                idx_s;

    // Select the operand slice addressed by the word counter.
    always_comb begin
        idx_s     = int'(cnt_r) * WORD_W;
        a_slice_s = a_r[idx_s +: WORD_W];
        b_slice_s = b_r[idx_s +: WORD_W];
        last_s    = (cnt_r == LAST_CNT);
    end

    cla_cin #(
        .WORD_W (WORD_W)
    ) u_cla (
        .i_data_a (a_slice_s),
        .i_data_b (b_slice_s),
        .i_carry  (carry_r),
        .o_data   (sum_s),
        .o_carry  (word_carry_s)
    );

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  if (i_valid) state_s = S_RUN;  else state_s = S_IDLE;
            S_RUN:   if (last_s)  state_s = S_DONE; else state_s = S_RUN;
            S_DONE:  if (i_ready) state_s = S_IDLE; else state_s = S_DONE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, word-serial accumulation and result holding.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_r    <= '0;
            carry_r  <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            data_r   <= '0;
            ocarry_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (i_valid) begin
                        // Subtraction is A + ~B + 1: invert B once here, carry-in seeds the +1.
                        a_r     <= i_data_a;
                        b_r     <= i_sub ? ~i_data_b : i_data_b;
                        carry_r <= i_sub;
                        cnt_r   <= '0;
                    end
                end
                S_RUN: begin
                    data_r[idx_s +: WORD_W] <= sum_s;
                    carry_r                 <= word_carry_s;
                    if (last_s) begin
                        ocarry_r <= word_carry_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_ready = (state_r == S_IDLE);
    assign o_valid = (state_r == S_DONE);
    assign o_busy  = (state_r == S_RUN) || (state_r == S_DONE);
    assign o_data  = data_r;
    assign o_carry = ocarry_r;

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq: directed cases plus randomized ops for N=4 and N=1.
module tb_wide_add_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   valid;
    logic [1:0]   sub;
    logic [1:0]   rdy_in;
    logic [127:0] a [2];
    logic [127:0] b [2];
    logic [1:0]   o_ready_w;
    logic [1:0]   o_valid_w;
    logic [1:0]   o_carry_w;
    logic [1:0]   o_busy_w;
    logic [127:0] d4;
    logic [31:0]  d1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wide_add_seq #(.WORD_W(32), .NUM_WORDS(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid[0]), .o_ready(o_ready_w[0]),
        .i_sub(sub[0]), .i_data_a(a[0]), .i_data_b(b[0]), .o_valid(o_valid_w[0]),
        .i_ready(rdy_in[0]), .o_data(d4), .o_carry(o_carry_w[0]), .o_busy(o_busy_w[0])
    );

    wide_add_seq #(.WORD_W(32), .NUM_WORDS(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid[1]), .o_ready(o_ready_w[1]),
        .i_sub(sub[1]), .i_data_a(a[1][31:0]), .i_data_b(b[1][31:0]), .o_valid(o_valid_w[1]),
        .i_ready(rdy_in[1]), .o_data(d1), .o_carry(o_carry_w[1]), .o_busy(o_busy_w[1])
    );

    function automatic logic [127:0] data_of(input int w);
        return (w == 0) ? d4 : {96'd0, d1};
    endfunction

    // Reference: plain arithmetic on the full operand width; carry = unsigned overflow / no-borrow.
    function automatic logic [128:0] model(input int w, input logic [127:0] x, input logic [127:0] y,
                                           input logic s);
        logic [127:0] mask;
        logic [128:0] full;
        logic [127:0] sum;
        logic         cy;
        int           width;
        width = (w == 0) ? 128 : 32;
        mask  = (w == 0) ? {128{1'b1}} : 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF;
        x = x & mask;
        y = y & mask;
        if (s) begin
            sum = (x - y) & mask;
            cy  = (x >= y);
        end else begin
            full = {1'b0, x} + {1'b0, y};
            sum  = full[127:0] & mask;
            cy   = full[width];
        end
        return {cy, sum};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction; operands are scrambled right after the accept edge.
    task automatic run_op(input int w, input logic [127:0] x, input logic [127:0] y, input logic s,
                          input bit stall, output logic [128:0] res, output int lat);
        int g;
        if (stall) repeat ($urandom_range(0, 2)) tick();
        valid[w] = 1'b1;
        a[w] = x;
        b[w] = y;
        sub[w] = s;
        g = 0;
        while (!o_ready_w[w] && g < 64) begin
            tick();
            g++;
        end
        if (g >= 64) check("accept_timeout", {128'd0, o_ready_w[w]}, 129'd1);
        tick();
        valid[w] = 1'b0;
        a[w] = {$urandom, $urandom, $urandom, $urandom};
        b[w] = {$urandom, $urandom, $urandom, $urandom};
        sub[w] = ~s;
        lat = 0;
        while (!o_valid_w[w] && lat < 64) begin
            tick();
            lat++;
        end
        res = {o_carry_w[w], data_of(w)};
        g = 0;
        do begin
            rdy_in[w] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            g++;
        end while (!rdy_in[w] && g < 64);
        rdy_in[w] = 1'b0;
    endtask

    initial begin
        logic [128:0] res;
        logic [128:0] exp_r;
        logic [127:0] x;
        logic [127:0] y;
        logic         s;
        logic         seen;
        int           lat;

        rst = 1'b1;
        valid = 2'b00;
        sub = 2'b00;
        rdy_in = 2'b00;
        a[0] = '0; b[0] = '0; a[1] = '0; b[1] = '0;
        tick();
        tick();
        check("rst_ready", {128'd0, o_ready_w[0]}, 129'd1);
        check("rst_valid", {128'd0, o_valid_w[0]}, 129'd0);
        check("rst_busy", {128'd0, o_busy_w[0]}, 129'd0);
        check("rst_data", {o_carry_w[0], d4}, 129'd0);
        check("rst_ready_n1", {128'd0, o_ready_w[1]}, 129'd1);
        rst = 1'b0;
        tick();

        // Carry propagating across three word boundaries.
        run_op(0, 128'h0000_0001_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0, res, lat);
        check("add_chain", res, {1'b0, 128'h0000_0002_0000_0000_0000_0000_0000_0000});
        check("latency4", 129'(lat), 129'd4);

        run_op(0, {128{1'b1}}, 128'd1, 1'b0, 1'b0, res, lat);
        check("overflow", res, {1'b1, 128'd0});

        run_op(0, 128'd5, 128'd7, 1'b1, 1'b0, res, lat);
        check("sub_borrow", res, {1'b0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE});
        run_op(0, 128'd7, 128'd5, 1'b1, 1'b0, res, lat);
        check("sub_noborrow", res, {1'b1, 128'd2});

        // Backpressure: result held, a waiting request is not taken until after the bubble.
        x = {$urandom, $urandom, $urandom, $urandom};
        y = {$urandom, $urandom, $urandom, $urandom};
        valid[0] = 1'b1; a[0] = x; b[0] = y; sub[0] = 1'b0;
        tick();
        exp_r = model(0, x, y, 1'b0);
        x = {$urandom, $urandom, $urandom, $urandom};
        y = {$urandom, $urandom, $urandom, $urandom};
        a[0] = x; b[0] = y; sub[0] = 1'b1;
        repeat (4) tick();
        check("bp_valid_rise", {128'd0, o_valid_w[0]}, 129'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid_hold", {128'd0, o_valid_w[0]}, 129'd1);
            check("bp_data_hold", {o_carry_w[0], d4}, exp_r);
            check("bp_no_accept", {128'd0, o_ready_w[0]}, 129'd0);
        end
        rdy_in[0] = 1'b1;
        tick();
        rdy_in[0] = 1'b0;
        check("bp_bubble_ready", {128'd0, o_ready_w[0]}, 129'd1);
        check("bp_bubble_valid", {128'd0, o_valid_w[0]}, 129'd0);
        tick();
        valid[0] = 1'b0;
        check("bp_accept_busy", {128'd0, o_busy_w[0]}, 129'd1);
        repeat (4) tick();
        check("bp_second_result", {o_carry_w[0], d4}, model(0, x, y, 1'b1));
        rdy_in[0] = 1'b1;
        tick();
        rdy_in[0] = 1'b0;

        // Reset in the second RUN cycle aborts the transaction.
        valid[0] = 1'b1; a[0] = 128'd1; b[0] = 128'd1; sub[0] = 1'b0;
        tick();
        valid[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", {128'd0, o_ready_w[0]}, 129'd1);
        check("abort_data", {o_carry_w[0], d4}, 129'd0);
        check("abort_busy", {128'd0, o_busy_w[0]}, 129'd0);
        seen = 1'b0;
        repeat (8) begin
            seen = seen | o_valid_w[0];
            tick();
        end
        check("abort_no_valid", {128'd0, seen}, 129'd0);
        x = 128'h8000_0000_0000_0000_FFFF_FFFF_0000_0001;
        y = 128'h8000_0000_0000_0001_0000_0001_FFFF_FFFF;
        run_op(0, x, y, 1'b0, 1'b0, res, lat);
        check("abort_next_op", res, model(0, x, y, 1'b0));

        // Single-word configuration.
        run_op(1, 128'hFFFF_FFFF, 128'd1, 1'b0, 1'b0, res, lat);
        check("n1_overflow", res, {1'b1, 128'd0});
        check("latency1", 129'(lat), 129'd1);
        run_op(1, 128'd3, 128'd5, 1'b1, 1'b0, res, lat);
        check("n1_sub", res, {1'b0, 128'hFFFF_FFFE});

        // Randomized operands and handshake stalls on both configurations.
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 1000; k++) begin
                x = {$urandom, $urandom, $urandom, $urandom};
                y = {$urandom, $urandom, $urandom, $urandom};
                if ($urandom_range(0, 7) == 0) x = {128{1'b1}};
                if ($urandom_range(0, 7) == 0) y = x;
                s = 1'($urandom_range(0, 1));
                run_op(w, x, y, s, 1'b1, res, lat);
                check((w == 0) ? "rand_n4" : "rand_n1", res, model(w, x, y, s));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
